// File: rtl/lisa_autobaud_pkg.sv
// lisa_autobaud_pkg
// Shared types and constants for the auto-baud detector.
//   ab_state_e : detector FSM states
//   AB_EDGES   : falling edges in a 0x55 sync character (start + 4 data)
//   AB_SHIFT   : log2(16x oversample * 8 bit times)
//   AB_ROUND   : half of 2^AB_SHIFT, rounds the span to nearest divider
//   AB_DIV_W   : width of the debug_brg divider
//   ab_in_tol  : |ik - i1| <= i1/4 interval tolerance test
package lisa_autobaud_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_HIGH  = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_MEASURE    = 2'd2,
        ST_CHECK      = 2'd3
    } ab_state_e;

    localparam int AB_EDGES = 5;
    localparam int AB_SHIFT = 7;
    localparam int AB_ROUND = 64;
    localparam int AB_DIV_W = 7;
    localparam int AB_Q_MAX = 1 << AB_DIV_W;

    function automatic logic ab_in_tol(input logic [31:0] ik, input logic [31:0] i1);
        logic [31:0] d;
        d = (ik > i1) ? (ik - i1) : (i1 - ik);
        return (d <= (i1 >> 2));
    endfunction

endpackage

// File: rtl/lisa_rxd_sync.sv
// lisa_rxd_sync
// Two-flop synchronizer for the asynchronous serial line plus a registered
// falling-edge pulse. The pulse is aligned with the first cycle o_rxd_s
// reads low, so every edge sees the same fixed latency.
//   clk, rst_n : clock, async active-low reset
//   i_rxd      : raw serial line
//   o_rxd_s    : synchronized line level
//   o_fall     : one-cycle pulse on a synchronized falling edge
module lisa_rxd_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_fall;

    // Reset to the idle (high) level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_rxd;
            r_s2   <= r_s1;
            r_fall <= r_s2 & ~r_s1;
        end
    end

    assign o_rxd_s = r_s2;
    assign o_fall  = r_fall;

endmodule

// File: rtl/lisa_autobaud.sv
// lisa_autobaud
// Measures a 0x55 sync character on the serial line (first to fifth falling
// edge = 8 bit times) and converts it into the debug_brg divider.
// Optional macro LISA_AUTOBAUD_TOL_CHECK_EN adds a per-interval consistency
// check (each 2-bit-time interval within 25% of the first).
//   clk, rst_n   : clock, async active-low reset
//   i_rxd        : raw serial line (asynchronous)
//   i_start      : single-cycle re-arm request
//   o_baud_set   : high once any measurement has locked
//   o_baud_div   : divider for debug_brg (baud_ref period = div+1)
//   o_lock       : one-cycle pulse on an accepted measurement
//   o_err        : one-cycle pulse on a rejected / timed-out measurement
//   o_busy       : high while measuring
module lisa_autobaud
    import lisa_autobaud_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int IDLE_MIN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rxd,
    input  logic                i_start,
    output logic                o_baud_set,
    output logic [AB_DIV_W-1:0] o_baud_div,
    output logic                o_lock,
    output logic                o_err,
    output logic                o_busy
);

    localparam int               IDLE_W   = $clog2(IDLE_MIN + 1);
    localparam logic [CNT_W-1:0] SPAN_MAX = '1;

    ab_state_e           r_state, w_state_nx;
    logic [IDLE_W-1:0]   r_idle;
    logic [CNT_W-1:0]    r_span;
    logic [2:0]          r_edge_cnt;
    logic                r_baud_set, r_lock, r_err, r_busy;
    logic [AB_DIV_W-1:0] r_baud_div;

    logic                w_rxd_s, w_fall, w_idle_done;
    logic                w_arm, w_cap, w_load, w_lock_nx, w_err_nx;
    logic [CNT_W:0]      w_sum, w_q;
    logic [AB_DIV_W-1:0] w_div;
    logic                w_range_ok, w_tol_ok, w_ok;

    lisa_rxd_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rxd   (i_rxd),
        .o_rxd_s (w_rxd_s),
        .o_fall  (w_fall)
    );

    assign w_idle_done = w_rxd_s && (r_idle == IDLE_W'(IDLE_MIN - 1));

    // Round span (8 bit times) to 16x-oversample units: q = (span+64)>>7.
    assign w_sum      = {1'b0, r_span} + (CNT_W+1)'(AB_ROUND);
    assign w_q        = w_sum >> AB_SHIFT;
    assign w_range_ok = (w_q != '0) && (w_q <= (CNT_W+1)'(AB_Q_MAX));
    assign w_div      = AB_DIV_W'(w_q - (CNT_W+1)'(1));
    assign w_ok       = w_range_ok && w_tol_ok;

`ifdef LISA_AUTOBAUD_TOL_CHECK_EN
    logic [CNT_W-1:0]       r_prev;
    logic [3:0][CNT_W-1:0]  r_int;
    logic [CNT_W-1:0]       w_now;
    logic [1:0]             w_idx;

    // Span value at the edge (counter advances in the same cycle).
    assign w_now = r_span + CNT_W'(1);
    assign w_idx = 2'(r_edge_cnt - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_int  <= '0;
        end else if (w_arm) begin
            r_prev <= '0;
            r_int  <= '0;
        end else if (w_cap) begin
            r_int[w_idx] <= w_now - r_prev;
            r_prev       <= w_now;
        end
    end

    always_comb begin
        w_tol_ok = 1'b1;
        for (int k = 1; k < 4; k++) begin
            if (!ab_in_tol(32'(r_int[k]), 32'(r_int[0])))
                w_tol_ok = 1'b0;
        end
    end
`else
    assign w_tol_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_HIGH;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_arm      = 1'b0;
        w_cap      = 1'b0;
        w_load     = 1'b0;
        w_lock_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            ST_WAIT_HIGH: begin
                if (w_idle_done) w_state_nx = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_fall) begin
                    w_arm      = 1'b1;
                    w_state_nx = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    w_cap = 1'b1;
                    if (r_edge_cnt == 3'(AB_EDGES - 1)) w_state_nx = ST_CHECK;
                end else if (r_span == SPAN_MAX) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = ST_WAIT_HIGH;
                end
            end
            ST_CHECK: begin
                w_state_nx = ST_WAIT_HIGH;
                if (w_ok) begin
                    w_load    = 1'b1;
                    w_lock_nx = 1'b1;
                end else begin
                    w_err_nx  = 1'b1;
                end
            end
            default: w_state_nx = ST_WAIT_HIGH;
        endcase
        // Re-arm overrides everything, including a completing measurement.
        if (i_start) begin
            w_state_nx = ST_WAIT_HIGH;
            w_arm      = 1'b0;
            w_cap      = 1'b0;
            w_load     = 1'b0;
            w_lock_nx  = 1'b0;
            w_err_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle     <= '0;
            r_span     <= '0;
            r_edge_cnt <= '0;
        end else begin
            if (r_state != ST_WAIT_HIGH || i_start || !w_rxd_s)
                r_idle <= '0;
            else if (!w_idle_done)
                r_idle <= r_idle + IDLE_W'(1);

            if (w_arm) begin
                r_span     <= '0;
                r_edge_cnt <= 3'd1;
            end else if (r_state == ST_MEASURE) begin
                // Saturation is the timeout condition, so hold at max.
                if (r_span != SPAN_MAX) r_span <= r_span + CNT_W'(1);
                if (w_cap) r_edge_cnt <= r_edge_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_set <= 1'b0;
            r_baud_div <= '0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_lock <= w_lock_nx;
            r_err  <= w_err_nx;
            r_busy <= (w_state_nx == ST_MEASURE);
            if (w_load) begin
                r_baud_div <= w_div;
                r_baud_set <= 1'b1;
            end
        end
    end

    assign o_baud_set = r_baud_set;
    assign o_baud_div = r_baud_div;
    assign o_lock     = r_lock;
    assign o_err      = r_err;
    assign o_busy     = r_busy;

endmodule
